// File: rtl/ahb3lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb3lite_cmd_master
//   AHB3-Lite initiator. Turns a valid/ready command into a single NONSEQ
//   transfer (one outstanding at a time). Completion is reported on a
//   one-cycle rsp_valid strobe together with read data and error status.
//
// Ports
//   HCLK, HRESETn            bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/size/wdata command fields (wdata already lane-placed)
//   rsp_valid/rdata/err      completion strobe, read data, error flag
//   HSEL..HWDATA             registered AHB master outputs
//   HRDATA, HREADY, HRESP    AHB slave response inputs
// ---------------------------------------------------------------------------
module ahb3lite_cmd_master #(
   parameter int         HADDR_SIZE = 32,
   parameter int         HDATA_SIZE = 32,
   parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [HADDR_SIZE-1:0] cmd_addr,
   input  logic [2:0]            cmd_size,
   input  logic [HDATA_SIZE-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [HDATA_SIZE-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  HSEL,
   output logic [HADDR_SIZE-1:0] HADDR,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [1:0]            HTRANS,
   output logic [HDATA_SIZE-1:0] HWDATA,
   input  logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   // Largest HSIZE the data bus can carry: log2(HDATA_SIZE/8).
   localparam logic [2:0] MAX_SIZE = (HDATA_SIZE == 64) ? 3'd3 : 3'd2;

   logic [1:0]            state;
   logic [HDATA_SIZE-1:0] wdata_q;
   logic [HADDR_SIZE-1:0] align_mask;
   logic                  cmd_legal;
   logic                  accept;

   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign cmd_ready = (state == ST_IDLE);
   assign accept    = cmd_valid & cmd_ready;

   always_comb begin
      align_mask = (HADDR_SIZE'(1) << cmd_size) - HADDR_SIZE'(1);
      cmd_legal  = (cmd_size <= MAX_SIZE) && ((cmd_addr & align_mask) == '0);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         wdata_q   <= '0;
         HSEL      <= 1'b0;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HSIZE     <= '0;
         HTRANS    <= TRANS_IDLE;
         HWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (cmd_legal) begin
                     state   <= ST_ADDR;
                     HSEL    <= 1'b1;
                     HTRANS  <= TRANS_NONSEQ;
                     HADDR   <= cmd_addr;
                     HWRITE  <= cmd_write;
                     HSIZE   <= cmd_size;
                     wdata_q <= cmd_wdata;
                  end else begin
                     // Rejected locally: answer next cycle, bus untouched.
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end
            end
            ST_ADDR: begin
               // Address phase held while a previous data phase stalls HREADY.
               if (HREADY) begin
                  state  <= ST_DATA;
                  HSEL   <= 1'b0;
                  HTRANS <= TRANS_IDLE;
                  if (HWRITE) HWDATA <= wdata_q;
               end
            end
            ST_DATA: begin
               // HREADY low covers both wait states and the first ERROR cycle.
               if (HREADY) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= HRESP;
                  if (HRESP)        rsp_rdata <= '0;
                  else if (!HWRITE) rsp_rdata <= HRDATA;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
module tb_ahb3lite_cmd_master;

   logic        HCLK;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int total = 0;
   int bad   = 0;

   ahb3lite_cmd_master #(
      .HADDR_SIZE(32),
      .HDATA_SIZE(32),
      .HPROT_VAL (4'b0011)
   ) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_size (cmd_size),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .HSEL     (HSEL),
      .HADDR    (HADDR),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HBURST   (HBURST),
      .HPROT    (HPROT),
      .HTRANS   (HTRANS),
      .HWDATA   (HWDATA),
      .HRDATA   (HRDATA),
      .HREADY   (HREADY),
      .HRESP    (HRESP)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // ---------------- small word-memory slave ----------------
   int          waits_cfg = 0;
   logic        err_cfg   = 1'b0;
   logic        hold_bus  = 1'b0;
   logic        dp_active;
   logic        dp_write;
   logic        dp_err;
   logic [31:0] dp_addr;
   logic [2:0]  dp_size;
   int          dp_cnt;
   logic [3:0]  lane_en;
   logic [31:0] mem [16];

   always_comb begin
      lane_en = 4'b0000;
      case (dp_size)
         3'd0:    lane_en = 4'b0001 << dp_addr[1:0];
         3'd1:    lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
      if (hold_bus && !dp_active) begin
         HREADY = 1'b0;
         HRESP  = 1'b0;
      end else if (dp_active) begin
         HREADY = (dp_cnt == 0);
         HRESP  = dp_err;
      end else begin
         HREADY = 1'b1;
         HRESP  = 1'b0;
      end
      HRDATA = (dp_active && !dp_write && !dp_err) ? mem[dp_addr[5:2]] : 32'h0;
   end

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_active <= 1'b0;
         dp_write  <= 1'b0;
         dp_err    <= 1'b0;
         dp_addr   <= 32'h0;
         dp_size   <= 3'd0;
         dp_cnt    <= 0;
      end else if (HREADY) begin
         if (dp_active && dp_write && !dp_err)
            for (int b = 0; b < 4; b++)
               if (lane_en[b]) mem[dp_addr[5:2]][8*b +: 8] <= HWDATA[8*b +: 8];
         dp_active <= HSEL && (HTRANS == 2'b10);
         dp_write  <= HWRITE;
         dp_addr   <= HADDR;
         dp_size   <= HSIZE;
         dp_err    <= err_cfg;
         dp_cnt    <= err_cfg ? 1 : waits_cfg;
      end else if (dp_active) begin
         dp_cnt <= dp_cnt - 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command and wait (bounded) for its response strobe.
   task automatic do_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d, output int lat,
                         output logic [1:0] tr_seen, output logic [2:0] sz_seen);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_size  = s;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
      tr_seen   = HTRANS;
      sz_seen   = HSIZE;
      lat       = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1'b1);
   endtask

   int         lat;
   logic [1:0] tr;
   logic [2:0] sz;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      HRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_size  = 3'd0;
      cmd_wdata = 32'h0;
      repeat (2) @(posedge HCLK);
      #1;

      // reset values
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_hsel", HSEL, 1'b0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("hburst", HBURST, 3'b000);
      chk("hprot", HPROT, 4'b0011);
      HRESETn = 1'b1;
      tick();

      // write DEADBEEF to 0x10, zero waits, step by step
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
      cmd_size = 3'd2; cmd_wdata = 32'hDEADBEEF;
      tick();
      cmd_valid = 1'b0; cmd_wdata = 32'h0;
      chk("wr_a_htrans", HTRANS, 2'b10);
      chk("wr_a_hsel", HSEL, 1'b1);
      chk("wr_a_haddr", HADDR, 32'h10);
      chk("wr_a_hwrite", HWRITE, 1'b1);
      chk("wr_a_hsize", HSIZE, 3'd2);
      chk("wr_a_ready", cmd_ready, 1'b0);
      tick();
      chk("wr_d_htrans", HTRANS, 2'b00);
      chk("wr_d_hsel", HSEL, 1'b0);
      chk("wr_d_hwdata", HWDATA, 32'hDEADBEEF);
      chk("wr_d_rsp", rsp_valid, 1'b0);
      tick();
      chk("wr_rsp_valid", rsp_valid, 1'b1);
      chk("wr_rsp_err", rsp_err, 1'b0);
      chk("wr_rsp_ready", cmd_ready, 1'b1);
      tick();
      chk("wr_rsp_one_cycle", rsp_valid, 1'b0);

      // read 0x10 with 2 data-phase wait states
      waits_cfg = 2;
      do_cmd(1'b0, 32'h10, 3'd2, 32'h0, lat, tr, sz);
      chk("rd_w2_latency", lat, 4);
      chk("rd_w2_trans_seen", tr, 2'b10);
      chk("rd_w2_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("rd_w2_err", rsp_err, 1'b0);
      waits_cfg = 0;

      // wait-state stability, stepwise read of 0x10 again
      waits_cfg = 2;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_size = 3'd2;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("rdw_d1_hready", HREADY, 1'b0);
      chk("rdw_d1_htrans", HTRANS, 2'b00);
      chk("rdw_d1_haddr", HADDR, 32'h10);
      tick();
      chk("rdw_d2_htrans", HTRANS, 2'b00);
      chk("rdw_d2_haddr", HADDR, 32'h10);
      chk("rdw_d2_rsp", rsp_valid, 1'b0);
      chk("rdw_d2_hwdata_held", HWDATA, 32'hDEADBEEF);
      tick();
      tick();
      chk("rdw_rsp_valid", rsp_valid, 1'b1);
      waits_cfg = 0;
      tick();

      // two-cycle ERROR on a read
      err_cfg = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_size = 3'd2;
      tick();
      cmd_valid = 1'b0;
      tick();
      err_cfg = 1'b0;
      chk("err1_hresp", HRESP, 1'b1);
      chk("err1_hready", HREADY, 1'b0);
      chk("err1_htrans", HTRANS, 2'b00);
      tick();
      chk("err2_htrans", HTRANS, 2'b00);
      chk("err2_rsp", rsp_valid, 1'b0);
      tick();
      chk("err_rsp_valid", rsp_valid, 1'b1);
      chk("err_rsp_err", rsp_err, 1'b1);
      chk("err_rsp_rdata", rsp_rdata, 32'h0);
      tick();

      // illegal: misaligned halfword, oversize
      do_cmd(1'b1, 32'h11, 3'd1, 32'h1234, lat, tr, sz);
      chk("ill_hw_latency", lat, 0);
      chk("ill_hw_trans", tr, 2'b00);
      chk("ill_hw_err", rsp_err, 1'b1);
      chk("ill_hw_ready", cmd_ready, 1'b1);
      tick();
      do_cmd(1'b0, 32'h10, 3'd3, 32'h0, lat, tr, sz);
      chk("ill_sz3_latency", lat, 0);
      chk("ill_sz3_trans", tr, 2'b00);
      chk("ill_sz3_err", rsp_err, 1'b1);
      tick();
      chk("ill_sz3_hsel", HSEL, 1'b0);

      // byte and halfword writes, then read back
      do_cmd(1'b1, 32'h13, 3'd0, 32'hAB00_0000, lat, tr, sz);
      chk("byte_hsize", sz, 3'd0);
      chk("byte_latency", lat, 2);
      chk("byte_err", rsp_err, 1'b0);
      tick();
      do_cmd(1'b1, 32'h14, 3'd1, 32'h0000_1234, lat, tr, sz);
      chk("half_hsize", sz, 3'd1);
      chk("half_err", rsp_err, 1'b0);
      tick();
      do_cmd(1'b0, 32'h10, 3'd2, 32'h0, lat, tr, sz);
      chk("rd10_rdata", rsp_rdata, 32'hABADBEEF);
      tick();
      do_cmd(1'b0, 32'h14, 3'd2, 32'h0, lat, tr, sz);
      chk("rd14_rdata", rsp_rdata, 32'h0000_1234);
      tick();
      chk("rdata_holds", rsp_rdata, 32'h0000_1234);

      // address phase stalled by HREADY low
      hold_bus  = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20;
      cmd_size = 3'd2; cmd_wdata = 32'h0000_55AA;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("stall_htrans", HTRANS, 2'b10);
      chk("stall_haddr", HADDR, 32'h20);
      chk("stall_hsel", HSEL, 1'b1);
      hold_bus = 1'b0;
      tick();
      chk("stall_d_hwdata", HWDATA, 32'h0000_55AA);
      tick();
      chk("stall_rsp", rsp_valid, 1'b1);
      tick();

      // reset during a data-phase wait state
      waits_cfg = 3;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14; cmd_size = 3'd2;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mid_wait_hready", HREADY, 1'b0);
      HRESETn = 1'b0;
      #1;
      chk("mid_rst_hsel", HSEL, 1'b0);
      chk("mid_rst_htrans", HTRANS, 2'b00);
      chk("mid_rst_haddr", HADDR, 32'h0);
      chk("mid_rst_hwrite", HWRITE, 1'b0);
      chk("mid_rst_hsize", HSIZE, 3'd0);
      chk("mid_rst_hwdata", HWDATA, 32'h0);
      chk("mid_rst_rdata", rsp_rdata, 32'h0);
      chk("mid_rst_err", rsp_err, 1'b0);
      chk("mid_rst_ready", cmd_ready, 1'b1);
      tick();
      HRESETn = 1'b1;
      waits_cfg = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_no_rsp", rsp_valid, 1'b0);
      end
      chk("post_rst_ready", cmd_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
